rv32i_mem_arbiter: RTL and testbench



---
 rtl/rv32i_arb_pkg.sv | 13 +
 rtl/rv32i_arb_pick.sv | 27 ++
 rtl/rv32i_mem_arbiter.sv | 105 ++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_arb_pkg.sv
// rv32i_arb_pkg: shared types and defaults for the IFU/LSU memory arbiter
package rv32i_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  typedef enum logic {OWN_IF, OWN_LS} arb_owner_e;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } arb_req_t;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/rv32i_arb_pick.sv
// rv32i_arb_pick: LSU-priority select with IFU starvation counter
module rv32i_arb_pick
  import rv32i_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                if_valid_i,
  input  logic                                ls_valid_i,
  input  logic                                grant_i,
  output arb_owner_e                          winner_o,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]  starve_cnt_o
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt_q;
  logic          starved;
  assign starved = if_valid_i && starve_cnt_q == SW'(STARVE_LIMIT);
  assign winner_o = (ls_valid_i && !starved) ? OWN_LS : OWN_IF;
  assign starve_cnt_o = starve_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= '0;
    else if (grant_i)
      starve_cnt_q <= (winner_o == OWN_IF) ? '0 :
                      (if_valid_i && !starved) ? starve_cnt_q + 1'b1 : starve_cnt_q;
  end
endmodule

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: single-outstanding arbiter sharing one memory port between IFU and LSU
module rv32i_mem_arbiter
  import rv32i_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_rdata,
  output logic        if_rsp_err,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [31:0] ls_req_addr,
  input  logic        ls_req_we,
  input  logic [3:0]  ls_req_be,
  input  logic [31:0] ls_req_wdata,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rsp_rdata,
  output logic        ls_rsp_err,
  output logic        mem_req,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  arb_state_e    state_q;
  arb_owner_e    owner_q, winner;
  arb_req_t      req_q;
  logic [TW-1:0] wait_cnt_q;
  logic [SW-1:0] starve_cnt;
  logic          grant, done, to_if, to_ls;
  logic [31:0]   rsp_rdata;
  rv32i_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk         (clk),
    .rst         (rst),
    .if_valid_i  (if_req_valid),
    .ls_valid_i  (ls_req_valid),
    .grant_i     (grant),
    .winner_o    (winner),
    .starve_cnt_o(starve_cnt)
  );
  assign if_req_ready = state_q == IDLE && !rst && if_req_valid && winner == OWN_IF;
  assign ls_req_ready = state_q == IDLE && !rst && ls_req_valid && winner == OWN_LS;
  assign grant = if_req_ready | ls_req_ready;
  // data arriving on the timeout cycle takes precedence over the error
  assign done = state_q == WAIT && (mem_rvalid || wait_cnt_q == TW'(TIMEOUT - 1));
  assign rsp_rdata = (mem_rvalid && !req_q.we) ? mem_rdata : '0;
  assign to_if = done && owner_q == OWN_IF;
  assign to_ls = done && owner_q == OWN_LS;
  assign mem_req = state_q == ISSUE;
  assign mem_addr = req_q.addr;
  assign mem_we = req_q.we;
  assign mem_be = req_q.be;
  assign mem_wdata = req_q.wdata;
  assign busy = state_q != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      req_q <= '0;
      wait_cnt_q <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_rdata <= '0;
      if_rsp_err <= 1'b0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_rdata <= '0;
      ls_rsp_err <= 1'b0;
    end else begin
      if_rsp_valid <= to_if;
      if_rsp_rdata <= to_if ? rsp_rdata : '0;
      if_rsp_err <= to_if && !mem_rvalid;
      ls_rsp_valid <= to_ls;
      ls_rsp_rdata <= to_ls ? rsp_rdata : '0;
      ls_rsp_err <= to_ls && !mem_rvalid;
      case (state_q)
        IDLE: if (grant) begin
          state_q <= ISSUE;
          owner_q <= ls_req_ready ? OWN_LS : OWN_IF;
          req_q <= ls_req_ready ? arb_req_t'{ls_req_addr, ls_req_we, ls_req_be, ls_req_wdata}
                                : arb_req_t'{if_req_addr, 1'b0, 4'hF, 32'h0};
        end
        ISSUE: if (mem_ready) begin
          state_q <= WAIT;
          wait_cnt_q <= '0;
        end
        WAIT: begin
          state_q <= done ? RESP : WAIT;
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: scoreboard bench for the IFU/LSU memory arbiter
module tb_rv32i_mem_arbiter;
  localparam int TIMEOUT = 64;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req_valid = 1'b0, if_req_ready;
  logic [31:0] if_req_addr = '0;
  logic if_rsp_valid, if_rsp_err;
  logic [31:0] if_rsp_rdata;
  logic ls_req_valid = 1'b0, ls_req_ready, ls_req_we = 1'b0;
  logic [31:0] ls_req_addr = '0, ls_req_wdata = '0;
  logic [3:0] ls_req_be = '0;
  logic ls_rsp_valid, ls_rsp_err;
  logic [31:0] ls_rsp_rdata;
  logic mem_req, mem_ready, mem_we, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  typedef struct {
    logic        ls;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
  int rdy_cd = 0, rv_delay = 1, resp_cd = 0;
  logic [31:0] rd_data = '0;
  logic inject_rv = 1'b0;
  rv32i_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata), .if_rsp_err(if_rsp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_we(ls_req_we), .ls_req_be(ls_req_be), .ls_req_wdata(ls_req_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata), .ls_rsp_err(ls_rsp_err),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );
  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask
  // memory model: ready after rdy_cd held cycles, completion rv_delay cycles after accept (0 = never)
  initial begin
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      if (rst) resp_cd = 0;
      if (inject_rv) begin
        mem_rvalid = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
        inject_rv = 1'b0;
      end else if (resp_cd > 0) begin
        resp_cd--;
        if (resp_cd == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd_data;
        end
      end else if (mem_req && !rst) begin
        if (rdy_cd > 0) rdy_cd--;
        else begin
          mem_ready = 1'b1;
          resp_cd = rv_delay;
          acc_cyc = cyc;
        end
      end
    end
  end
  // monitor: every response pulse must match the oldest expectation
  initial forever begin
    @(negedge clk);
    if (if_rsp_valid && ls_rsp_valid) fail_now("both_rsp_valid");
    else if (if_rsp_valid || ls_rsp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got if=%0b ls=%0b expected none", if_rsp_valid, ls_rsp_valid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_owner", 64'(ls_rsp_valid), 64'(e.ls));
        check("rsp_rdata", 64'(e.ls ? ls_rsp_rdata : if_rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(e.ls ? ls_rsp_err : if_rsp_err), 64'(e.err));
        check("rsp_other_zero", e.ls ? {if_rsp_rdata, if_rsp_err} : {ls_rsp_rdata, ls_rsp_err}, 0);
      end
    end
  end
  task automatic do_req(input logic ls, input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee, input logic push);
    int n;
    @(negedge clk);
    if (ls) begin
      ls_req_valid = 1'b1; ls_req_addr = a; ls_req_we = we; ls_req_be = be; ls_req_wdata = wd;
    end else begin
      if_req_valid = 1'b1; if_req_addr = a;
    end
    if (push) sb.push_back('{ls, er, ee});
    for (n = 0; n < 300; n++) begin
      #1;
      if (ls ? ls_req_ready : if_req_ready) break;
      @(negedge clk);
    end
    if (n == 300) fail_now("req_ready");
    else @(posedge clk);
    #1;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (n == 300) fail_now("wait_idle");
  endtask
  task automatic wait_ls_rsp(output int lat);
    int n;
    lat = 0;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (ls_rsp_valid) break;
    end
    if (n == 300) fail_now("wait_ls_rsp");
    else lat = cyc - acc_cyc;
  endtask
  initial begin
    int lat, g;
    logic exp_ls;
    rst = 1'b1;
    if_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", {if_req_ready, ls_req_ready}, 0);
    check("rst_outs", {if_rsp_valid, if_rsp_rdata, if_rsp_err, ls_rsp_valid, ls_rsp_rdata, ls_rsp_err,
                       mem_req, mem_addr, mem_we, mem_be, mem_wdata, busy} == '0, 1);
    if_req_valid = 1'b0;
    rst = 1'b0;
    rdy_cd = 0; rv_delay = 2; rd_data = 32'h00500093;
    do_req(1'b0, 32'h100, 1'b0, 4'h0, 32'h0, 32'h00500093, 1'b0, 1'b1);
    check("fetch_mem_req", 64'(mem_req), 1);
    check("fetch_mem_fields", {mem_addr, mem_we, mem_be, mem_wdata}, {32'h100, 1'b0, 4'hF, 32'h0});
    wait_idle();
    rdy_cd = 1; rv_delay = 1; rd_data = 32'h12345678;
    do_req(1'b1, 32'h2000, 1'b1, 4'b0011, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    check("store_mem_req", 64'(mem_req), 1);
    check("store_mem_fields", {mem_addr, mem_we, mem_be, mem_wdata}, {32'h2000, 1'b1, 4'b0011, 32'hDEADBEEF});
    wait_idle();
    rdy_cd = 0; rv_delay = 1; rd_data = 32'h11111111;
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h400;
    ls_req_valid = 1'b1; ls_req_addr = 32'h3000; ls_req_we = 1'b0; ls_req_be = 4'hF;
    g = 0;
    for (int n = 0; n < 300 && g < 10; n++) begin
      #1;
      if (if_req_ready || ls_req_ready) begin
        exp_ls = (g % 5) != 4;
        check($sformatf("grant_%0d", g), {if_req_ready, ls_req_ready}, {!exp_ls, exp_ls});
        sb.push_back('{exp_ls, 32'h11111111, 1'b0});
        if (!exp_ls) begin
          check("starve_at_limit", 64'(u_dut.starve_cnt), 4);
          @(posedge clk);
          #1;
          check("starve_cleared", 64'(u_dut.starve_cnt), 0);
        end
        g++;
      end
      @(negedge clk);
    end
    if (g < 10) fail_now("contention_grants");
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    wait_idle();
    rdy_cd = 0; rv_delay = 0;
    do_req(1'b1, 32'h2004, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1);
    wait_ls_rsp(lat);
    check("timeout_latency", 64'(lat), TIMEOUT + 1);
    wait_idle();
    inject_rv = 1'b1;
    repeat (3) @(negedge clk);
    check("late_rvalid_ignored", {busy, if_rsp_valid, ls_rsp_valid, mem_req}, 0);
    rv_delay = TIMEOUT; rd_data = 32'hCAFE0001;
    do_req(1'b1, 32'h2008, 1'b0, 4'hF, 32'h0, 32'hCAFE0001, 1'b0, 1'b1);
    wait_ls_rsp(lat);
    check("data_wins_latency", 64'(lat), TIMEOUT + 1);
    wait_idle();
    rdy_cd = 70; rv_delay = 1; rd_data = 32'h0;
    do_req(1'b1, 32'h2010, 1'b1, 4'b1100, 32'hA5A5F00D, 32'h0, 1'b0, 1'b1);
    begin
      int bad = 0;
      for (int n = 0; n < 70; n++) begin
        @(negedge clk);
        if ({mem_req, mem_addr, mem_we, mem_be, mem_wdata} !== {1'b1, 32'h2010, 1'b1, 4'b1100, 32'hA5A5F00D} ||
            ls_rsp_valid) bad++;
      end
      check("backpressure_hold", 64'(bad), 0);
    end
    wait_idle();
    rdy_cd = 0; rv_delay = 0;
    do_req(1'b1, 32'h2020, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("in_wait", {busy, mem_req}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outs", {if_req_ready, ls_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err, ls_rsp_valid,
                          ls_rsp_rdata, ls_rsp_err, mem_req, mem_addr, mem_we, mem_be, mem_wdata, busy} == '0, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_idle", {busy, if_rsp_valid, ls_rsp_valid}, 0);
    rv_delay = 1; rd_data = 32'h00A00113;
    do_req(1'b0, 32'h104, 1'b0, 4'h0, 32'h0, 32'h00A00113, 1'b0, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
